fht_frame_loader: RTL and testbench
===================================

Name: fht_frame_loader

Overview:
- Synthesizable ADC-to-FHT input loader.
- Accepts a stream of unexpanded signed ADC samples and sign-extends each by one bit.
- Writes the samples as one frame into N_BANK RAM banks, with a bit-reversed bank counter.
- When the frame is complete, issues a one-cycle start pulse to the FHT core and waits for the core's ready level before loading the next frame.
- Sits between the ADC interface and the write port of fht_top (iDATA / iADDR_WR / iWE_x / iSTART / oRDY).

Parameters:
- D_BIT, 16: RAM word width. ADC sample width is D_BIT-1.
- N_BANK, 4: number of RAM banks. Power of 2, at least 2.
- BANK_SIZE, 256: words per bank. Power of 2, at least 2.
- BANK_REV, 1: 1 selects bit-reversed bank order; 0 selects natural bank order.
- A_BIT (localparam), $clog2(BANK_SIZE): bank address width.
- B_BIT (localparam), $clog2(N_BANK): bank index width.

Ports:
- iCLK, in, 1: single clock for the whole block.
- iRESET, in, 1: synchronous, active-high reset.
- iVALID, in, 1: ADC sample strobe.
- iDATA, in, D_BIT-1: signed ADC sample.
- oREADY, out, 1: loader is accepting samples.
- oDATA, out, D_BIT: sign-extended sample to RAM.
- oADDR_WR, out, A_BIT: RAM word address.
- oWE, out, N_BANK: one-hot bank write enable.
- oSTART, out, 1: one-cycle FHT start pulse.
- iRDY, in, 1: FHT ready level (fht_top oRDY).
- oBUSY, out, 1: high from the frame's first accepted sample until FHT completion.
- oDROP_CNT, out, 16: dropped-sample count. Present only with the optional feature.

Behaviour:
- Reset: all of the following are driven 0 on the first iCLK edge with iRESET=1:
  - oDATA, oADDR_WR, oWE, oSTART, oBUSY, oDROP_CNT.
  - Sample counter k.
  - State returns to LOAD.
- Reset mid-frame or mid-FHT: the partial frame is abandoned. No oSTART is issued for it.
- States:
  - LOAD:
    - oREADY=1.
    - When iVALID=1, the sample is accepted and k increments.
    - When k = N_BANK*BANK_SIZE-1 is accepted, go to START and clear k to 0.
  - START:
    - oREADY=0 and oSTART=1 for exactly one cycle.
    - Go to WAIT_ACK.
  - WAIT_ACK:
    - oREADY=0.
    - Stay until iRDY=0, then go to WAIT_DONE.
    - Guard: if iRDY stays high for 4 cycles, treat the start as accepted and go to WAIT_DONE.
  - WAIT_DONE:
    - oREADY=0.
    - When iRDY=1, go to LOAD.
- Write mapping for accepted sample k:
  - i = k[A_BIT+B_BIT-1:A_BIT]
  - oADDR_WR = k[A_BIT-1:0]
  - bank = bitreverse(i) if BANK_REV=1, otherwise i. With N_BANK=4, bank = {i[0],i[1]}.
  - oWE[bank]=1 and all other oWE bits are 0.
- Latency: outputs are registered. oDATA/oADDR_WR/oWE are valid 1 cycle after the accepting edge. oWE is high for exactly one cycle per accepted sample.
- oSTART occurs on the cycle after the last write cycle.
- oDATA = {iDATA[D_BIT-2], iDATA} (sign extension), held until the next accept.
- oBUSY:
  - Set on the first accept of a frame.
  - Cleared on the transition from WAIT_DONE to LOAD.
- iVALID while oREADY=0: the sample is dropped, no write occurs, and k is unchanged.
- Back-to-back iVALID in LOAD: one write per cycle, with no bubbles.

Optional Feature:
- Macro: FHT_LOADER_DROP_CNT_EN.
- When defined:
  - oDROP_CNT increments on every cycle with iVALID=1 and oREADY=0.
  - It saturates at 16'hFFFF.
  - It is cleared only by iRESET.
- When not defined:
  - The oDROP_CNT port is absent.
  - Dropped samples are silently discarded.
  - No counter logic is built.

Decomposition:
- Shared package fht_loader_pkg:
  - state enum {LOAD, START, WAIT_ACK, WAIT_DONE}.
  - Constant ACK_TIMEOUT = 4.
  - Function bitrev(value, width).
- One sub-module, fht_bank_addr_gen: combinational mapping k -> (bank one-hot, address), parametrised by N_BANK, BANK_SIZE and BANK_REV.

Test Plan:
- Natural load:
  - Setup: N_BANK=4, BANK_SIZE=8. Stream 32 samples, value=k, iVALID held high.
  - Writes:
    - k=0..7 go to bank 0, addresses 0..7.
    - k=8..15 go to bank 2.
    - k=16..23 go to bank 1.
    - k=24..31 go to bank 3.
  - Single oSTART 1 cycle after the k=31 write.
- Sign extension: sample 15'h4000 -> oDATA=16'hC000. Sample 15'h3FFF -> oDATA=16'h3FFF.
- Handshake:
  - After oSTART, drive iRDY low for 20 cycles, then high.
  - oREADY stays 0 until 1 cycle after iRDY rises.
  - oBUSY then falls.
  - The next frame restarts at k=0, bank 0, address 0.
- Drops (with FHT_LOADER_DROP_CNT_EN):
  - 5 iVALID pulses during WAIT_DONE -> no oWE, oDROP_CNT=5, k unchanged.
  - Saturation check: hold iVALID in WAIT_DONE for 70000 cycles -> oDROP_CNT=16'hFFFF.
- Reset mid-frame:
  - Assert iRESET after 13 accepts.
  - The following cycle shows all outputs at 0.
  - The next accepted sample is written to bank 0, address 0, and no oSTART occurs for the aborted frame.
- BANK_REV=0, N_BANK=8, BANK_SIZE=4: sample k=4 -> oWE=8'b0000_0010, address 0. Sample k=31 -> oWE=8'b1000_0000, address 3.

Source files
------------

// File: rtl/fht_loader_pkg.sv
// Shared types and helpers for the FHT frame loader: FSM state encoding, ack guard length, bit reversal.
package fht_loader_pkg;

  typedef enum logic [1:0] {LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

  localparam int ACK_TIMEOUT = 4;

  // Reverses the low 'width' bits of value; bits above width come back as 0.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
    logic [31:0] r;
    logic [4:0]  src;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        src  = 5'(width - 1 - i);
        r[i] = value[src];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fht_bank_addr_gen.sv
// Maps a frame sample index to a one-hot bank enable and an in-bank word address.
// Purely combinational, no latency; no flow control.
module fht_bank_addr_gen
  import fht_loader_pkg::*;
#(
  parameter int N_BANK    = 4,
  parameter int BANK_SIZE = 256,
  parameter int BANK_REV  = 1,
  localparam int A_BIT    = $clog2(BANK_SIZE),
  localparam int B_BIT    = $clog2(N_BANK)
) (
  input  logic [A_BIT+B_BIT-1:0] k,
  output logic [N_BANK-1:0]      we,
  output logic [A_BIT-1:0]       addr
);

  logic [B_BIT-1:0] idx;
  logic [B_BIT-1:0] bank;

  always_comb begin
    idx  = k[A_BIT +: B_BIT];
    bank = (BANK_REV != 0) ? B_BIT'(bitrev(32'(idx), B_BIT)) : idx;
    addr = k[A_BIT-1:0];
    we       = '0;
    we[bank] = 1'b1;
  end

endmodule

// File: rtl/fht_frame_loader.sv
// ADC-to-FHT frame loader; optional dropped-sample counter under FHT_LOADER_DROP_CNT_EN.
// RAM writes registered 1 cycle after accept; oREADY low from frame end until the FHT core reports done.
module fht_frame_loader
  import fht_loader_pkg::*;
#(
  parameter int D_BIT     = 16,
  parameter int N_BANK    = 4,
  parameter int BANK_SIZE = 256,
  parameter int BANK_REV  = 1,
  localparam int A_BIT    = $clog2(BANK_SIZE),
  localparam int B_BIT    = $clog2(N_BANK)
) (
  input  logic               iCLK,
  input  logic               iRESET,
  input  logic               iVALID,
  input  logic [D_BIT-2:0]   iDATA,
  output logic               oREADY,
  output logic [D_BIT-1:0]   oDATA,
  output logic [A_BIT-1:0]   oADDR_WR,
  output logic [N_BANK-1:0]  oWE,
  output logic               oSTART,
  input  logic               iRDY,
  output logic               oBUSY
`ifdef FHT_LOADER_DROP_CNT_EN
  ,
  output logic [15:0]        oDROP_CNT
`endif
);

  localparam int K_BIT = A_BIT + B_BIT;
  localparam logic [K_BIT-1:0] K_LAST = K_BIT'(N_BANK * BANK_SIZE - 1);

  state_t            state;
  state_t            state_nxt;
  logic [K_BIT-1:0]  k;
  logic [2:0]        ack_cnt;
  logic              accept;
  logic [N_BANK-1:0] we_map;
  logic [A_BIT-1:0]  addr_map;

  fht_bank_addr_gen #(
    .N_BANK    (N_BANK),
    .BANK_SIZE (BANK_SIZE),
    .BANK_REV  (BANK_REV)
  ) u_addr_gen (
    .k    (k),
    .we   (we_map),
    .addr (addr_map)
  );

  always_comb begin
    state_nxt = state;
    oREADY    = 1'b0;
    case (state)
      LOAD: begin
        oREADY = 1'b1;
        if (iVALID && (k == K_LAST)) state_nxt = START;
      end
      START:     state_nxt = WAIT_ACK;
      // A core that never drops iRDY still gets its start honoured after the guard interval.
      WAIT_ACK:  if (!iRDY || (ack_cnt == 3'(ACK_TIMEOUT - 1))) state_nxt = WAIT_DONE;
      WAIT_DONE: if (iRDY) state_nxt = LOAD;
      default:   state_nxt = LOAD;
    endcase
  end

  assign accept = iVALID & oREADY;

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state    <= LOAD;
      k        <= '0;
      ack_cnt  <= '0;
      oDATA    <= '0;
      oADDR_WR <= '0;
      oWE      <= '0;
      oSTART   <= 1'b0;
      oBUSY    <= 1'b0;
    end else begin
      state   <= state_nxt;
      oWE     <= '0;
      oSTART  <= (state == START);
      ack_cnt <= (state == WAIT_ACK) ? ack_cnt + 3'd1 : 3'd0;
      if (accept) begin
        oDATA    <= {iDATA[D_BIT-2], iDATA};
        oADDR_WR <= addr_map;
        oWE      <= we_map;
        k        <= (k == K_LAST) ? '0 : k + 1'b1;
        oBUSY    <= 1'b1;
      end
      if ((state == WAIT_DONE) && iRDY) oBUSY <= 1'b0;
    end
  end

`ifdef FHT_LOADER_DROP_CNT_EN
  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      oDROP_CNT <= '0;
    end else if (iVALID && !oREADY && (oDROP_CNT != 16'hFFFF)) begin
      oDROP_CNT <= oDROP_CNT + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fht_frame_loader.sv
// Bench for fht_frame_loader: a bit-reversed 4x8 instance and a natural-order 8x4 instance share one stimulus stream.
module tb_fht_frame_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, vld, rdy;
  logic [14:0] dat;

  logic        a_ready, a_start, a_busy;
  logic [15:0] a_data;
  logic [2:0]  a_addr;
  logic [3:0]  a_we;
  logic        b_ready, b_start, b_busy;
  logic [15:0] b_data;
  logic [1:0]  b_addr;
  logic [7:0]  b_we;
`ifdef FHT_LOADER_DROP_CNT_EN
  logic [15:0] a_drop, b_drop;
`endif

  int checks   = 0;
  int errors   = 0;
  int exp_drop = 0;

  fht_frame_loader #(.D_BIT(16), .N_BANK(4), .BANK_SIZE(8), .BANK_REV(1)) dut_a (
    .iCLK(clk), .iRESET(rst), .iVALID(vld), .iDATA(dat), .oREADY(a_ready),
    .oDATA(a_data), .oADDR_WR(a_addr), .oWE(a_we), .oSTART(a_start),
    .iRDY(rdy), .oBUSY(a_busy)
`ifdef FHT_LOADER_DROP_CNT_EN
    , .oDROP_CNT(a_drop)
`endif
  );

  fht_frame_loader #(.D_BIT(16), .N_BANK(8), .BANK_SIZE(4), .BANK_REV(0)) dut_b (
    .iCLK(clk), .iRESET(rst), .iVALID(vld), .iDATA(dat), .oREADY(b_ready),
    .oDATA(b_data), .oADDR_WR(b_addr), .oWE(b_we), .oSTART(b_start),
    .iRDY(rdy), .oBUSY(b_busy)
`ifdef FHT_LOADER_DROP_CNT_EN
    , .oDROP_CNT(b_drop)
`endif
  );

  // Reference: bank index of sample k from plain division and arithmetic bit reversal.
  function automatic int ref_bank(input int k, input int nb, input int bs, input bit rev);
    int i, lb, r;
    i  = (k / bs) % nb;
    lb = 0;
    while ((1 << lb) < nb) lb++;
    if (!rev) return i;
    r = 0;
    for (int b = 0; b < lb; b++) if (((i >> b) & 1) == 1) r += 1 << (lb - 1 - b);
    return r;
  endfunction

  function automatic logic [15:0] ref_sext(input logic [14:0] s);
    int v;
    v = int'(s);
    if (v >= 16384) v -= 32768;
    return 16'(v);
  endfunction

  task automatic check_idle_outputs(input string name);
    checks++;
    if (a_data !== 16'h0 || a_addr !== 3'h0 || a_we !== 4'h0 || a_start !== 1'b0 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s dut_a: data=%h addr=%h we=%b start=%b busy=%b, expected all 0",
               name, a_data, a_addr, a_we, a_start, a_busy);
    end
    checks++;
    if (b_data !== 16'h0 || b_addr !== 2'h0 || b_we !== 8'h0 || b_start !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s dut_b: data=%h addr=%h we=%b start=%b busy=%b, expected all 0",
               name, b_data, b_addr, b_we, b_start, b_busy);
    end
`ifdef FHT_LOADER_DROP_CNT_EN
    checks++;
    if (a_drop !== 16'h0 || b_drop !== 16'h0) begin
      errors++;
      $display("FAIL %s drop_cnt: a=%0d b=%0d, expected 0", name, a_drop, b_drop);
    end
`endif
  endtask

  // Streams n samples from k=0, checking every registered write against the reference mapping.
  task automatic load_frame(input int n, input bit gaps, input bit rnd);
    logic [14:0] s;
    for (int k = 0; k < n; k++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        vld = 1'b0;
        @(negedge clk);
        checks++;
        if (a_we !== 4'h0 || b_we !== 8'h0) begin
          errors++;
          $display("FAIL gap_no_write k=%0d: a_we=%b b_we=%b, expected 0", k, a_we, b_we);
        end
      end
      if (rnd) s = (k == 0) ? 15'h4000 : (k == 1) ? 15'h3FFF : 15'($urandom);
      else     s = 15'(k);
      vld = 1'b1;
      dat = s;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
        errors++;
        $display("FAIL ready_in_load k=%0d: a=%b b=%b, expected 1", k, a_ready, b_ready);
      end
      @(negedge clk);
      checks++;
      if (a_we !== 4'(1 << ref_bank(k, 4, 8, 1)) || a_addr !== 3'(k % 8) || a_data !== ref_sext(s)) begin
        errors++;
        $display("FAIL write_rev k=%0d: we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                 k, a_we, a_addr, a_data, 4'(1 << ref_bank(k, 4, 8, 1)), k % 8, ref_sext(s));
      end
      checks++;
      if (b_we !== 8'(1 << ref_bank(k, 8, 4, 0)) || b_addr !== 2'(k % 4) || b_data !== ref_sext(s)) begin
        errors++;
        $display("FAIL write_nat k=%0d: we=%b addr=%0d data=%h, expected we=%b addr=%0d data=%h",
                 k, b_we, b_addr, b_data, 8'(1 << ref_bank(k, 8, 4, 0)), k % 4, ref_sext(s));
      end
      checks++;
      if (a_busy !== 1'b1 || b_busy !== 1'b1 || a_start !== 1'b0 || b_start !== 1'b0) begin
        errors++;
        $display("FAIL busy_while_loading k=%0d: busy a=%b b=%b start a=%b b=%b, expected busy 1 start 0",
                 k, a_busy, b_busy, a_start, b_start);
      end
    end
    vld = 1'b0;
  endtask

  // Called on the write cycle of the last sample; returns on the oSTART cycle.
  task automatic expect_start();
    checks++;
    if (a_start !== 1'b0 || b_start !== 1'b0) begin
      errors++;
      $display("FAIL start_not_with_write: a=%b b=%b, expected 0", a_start, b_start);
    end
    @(negedge clk);
    checks++;
    if (a_start !== 1'b1 || b_start !== 1'b1 || a_we !== 4'h0 || b_we !== 8'h0 || a_ready !== 1'b0) begin
      errors++;
      $display("FAIL start_pulse: start a=%b b=%b we a=%b b=%b ready=%b, expected start 1 we 0 ready 0",
               a_start, b_start, a_we, b_we, a_ready);
    end
  endtask

  task automatic test_handshake(input int low_cycles);
    rdy = 1'b0;
    for (int c = 0; c < low_cycles; c++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0 || a_busy !== 1'b1 || a_start !== 1'b0 || b_start !== 1'b0) begin
        errors++;
        $display("FAIL fht_running c=%0d: ready a=%b b=%b busy=%b start a=%b b=%b, expected ready 0 busy 1 start 0",
                 c, a_ready, b_ready, a_busy, a_start, b_start);
      end
    end
    rdy = 1'b1;
    checks++;
    if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_done_edge: a=%b b=%b, expected 0", a_ready, b_ready);
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++;
      $display("FAIL fht_done: ready a=%b b=%b busy a=%b b=%b, expected ready 1 busy 0",
               a_ready, b_ready, a_busy, b_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b0; dat = '0; rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_idle_outputs("reset_state");
    rst = 1'b0;
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: a=%b b=%b, expected 1", a_ready, b_ready);
    end
  endtask

  task automatic test_natural_load();
    load_frame(32, 1'b0, 1'b0);
    expect_start();
    test_handshake(20);
  endtask

  task automatic test_random_frame();
    load_frame(32, 1'b1, 1'b1);
    expect_start();
    test_handshake(3 + $urandom_range(0, 10));
  endtask

  task automatic test_drops();
    load_frame(32, 1'b1, 1'b1);
    expect_start();
    rdy = 1'b0;
    @(negedge clk);
    for (int p = 0; p < 5; p++) begin
      vld = 1'b1;
      dat = 15'($urandom);
      @(negedge clk);
      vld = 1'b0;
      checks++;
      if (a_we !== 4'h0 || b_we !== 8'h0) begin
        errors++;
        $display("FAIL dropped_no_write p=%0d: a_we=%b b_we=%b, expected 0", p, a_we, b_we);
      end
      exp_drop++;
      @(negedge clk);
    end
`ifdef FHT_LOADER_DROP_CNT_EN
    checks++;
    if (a_drop !== 16'(exp_drop) || b_drop !== 16'(exp_drop)) begin
      errors++;
      $display("FAIL drop_count: a=%0d b=%0d, expected %0d", a_drop, b_drop, exp_drop);
    end
    vld = 1'b1;
    repeat (70000) @(negedge clk);
    vld = 1'b0;
    exp_drop = 65535;
    checks++;
    if (a_drop !== 16'hFFFF || b_drop !== 16'hFFFF) begin
      errors++;
      $display("FAIL drop_saturate: a=%h b=%h, expected ffff", a_drop, b_drop);
    end
`endif
    rdy = 1'b1;
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_drops_done: ready=%b busy=%b, expected ready 1 busy 0", a_ready, a_busy);
    end
    // Next frame must still begin at k=0, proving dropped samples left k alone.
    load_frame(32, 1'b0, 1'b1);
    expect_start();
    test_handshake(4);
  endtask

  task automatic test_ack_timeout();
    load_frame(32, 1'b0, 1'b1);
    expect_start();
    // iRDY never drops: 4 guard cycles in WAIT_ACK, then WAIT_DONE sees iRDY high.
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
        errors++;
        $display("FAIL ack_guard_hold c=%0d: a=%b b=%b, expected 0", c, a_ready, b_ready);
      end
    end
    @(negedge clk);
    checks++;
    if (a_ready !== 1'b1 || b_ready !== 1'b1 || a_busy !== 1'b0) begin
      errors++;
      $display("FAIL ack_guard_release: ready a=%b b=%b busy=%b, expected ready 1 busy 0",
               a_ready, b_ready, a_busy);
    end
  endtask

  task automatic test_reset_mid_frame();
    load_frame(13, 1'b1, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_mid_frame");
    rst = 1'b0;
    exp_drop = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if (a_start !== 1'b0 || b_start !== 1'b0 || a_ready !== 1'b1) begin
        errors++;
        $display("FAIL aborted_frame_quiet c=%0d: start a=%b b=%b ready=%b, expected start 0 ready 1",
                 c, a_start, b_start, a_ready);
      end
    end
    load_frame(32, 1'b1, 1'b1);
    expect_start();
    test_handshake(7);
  endtask

  initial begin
    test_reset();
    test_natural_load();
    test_random_frame();
    test_drops();
    test_ack_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
